// File: rtl/fft_pkg.sv
// fft_pkg: shared sequencer state encoding and constant log2 helper
package fft_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/fft_wb_delay.sv
// fft_wb_delay: shift register carrying read pairs forward to their write-back slot
module fft_wb_delay #(
  parameter int depth = 3,
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [aw-1:0] in_a,
  input  logic [aw-1:0] in_b,
  output logic          out_valid,
  output logic [aw-1:0] out_a,
  output logic [aw-1:0] out_b
);
  logic [depth-1:0] v;
  logic [aw-1:0] a [depth];
  logic [aw-1:0] b [depth];
  always_ff @(posedge clk) begin
    if (rst) v <= '0;
    else begin
      v[0] <= in_valid;
      for (int i = 1; i < depth; i++) v[i] <= v[i-1];
    end
    a[0] <= in_a;
    b[0] <= in_b;
    for (int i = 1; i < depth; i++) begin
      a[i] <= a[i-1];
      b[i] <= b[i-1];
    end
  end
  assign out_valid = v[depth-1];
  assign out_a = a[depth-1];
  assign out_b = b[depth-1];
endmodule

// File: rtl/fft_mem_seq.sv
// fft_mem_seq: in-place radix-2 DIT FFT RAM address/twiddle sequencer.
// Define FFT_MEM_SEQ_INV_EN to add the `inverse` port (conjugate twiddles).
module fft_mem_seq
  import fft_pkg::*;
#(
  parameter int size = 1024,
  parameter int addr_size = clog2(size),
  parameter int bf_lat = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef FFT_MEM_SEQ_INV_EN
  input  logic                 inverse,
`endif
  output logic [addr_size-1:0] addr_0,
  output logic [addr_size-1:0] addr_1,
  output logic                 wr_en_0,
  output logic                 wr_en_1,
  output logic [addr_size-1:0] tw_idx,
  output logic                 bf_in_valid,
  output logic [addr_size-1:0] stage,
  output logic                 busy,
  output logic                 done
);
  localparam int per = size + bf_lat;
  localparam int rw = clog2(per);
  if (bf_lat % 2 != 0) begin : g_lat_chk
    $error("fft_mem_seq: bf_lat must be even");
  end
  state_t st, nst;
  logic [rw-1:0] r, nr;
  logic [addr_size-1:0] nstage, na, nb, ctw, wb_a, wb_b;
  logic nrd, cur_rd, wb_v;
  function automatic logic [addr_size-1:0] leg_a(input logic [addr_size-1:0] k, input logic [addr_size-1:0] s);
    logic [addr_size-1:0] m;
    m = (addr_size'(1) << s) - addr_size'(1);
    return ((k >> s) << (s + 1)) | (k & m);
  endfunction
  function automatic logic [addr_size-1:0] tw_of(input logic [addr_size-1:0] k, input logic [addr_size-1:0] s);
    logic [addr_size-1:0] m;
    m = (addr_size'(1) << s) - addr_size'(1);
    return (k & m) << (addr_size'(addr_size - 1) - s);
  endfunction
  always_comb begin
    nst = st;
    nr = r;
    nstage = stage;
    if (st == IDLE && start) begin
      nst = RUN;
      nr = '0;
      nstage = '0;
    end else if (st == RUN) begin
      if (r != rw'(per - 1)) nr = r + 1'b1;
      else if (stage == addr_size'(addr_size - 1)) nst = DONE;
      else begin
        nr = '0;
        nstage = stage + 1'b1;
      end
    end else if (st == DONE) nst = IDLE;
    nrd = nst == RUN && !nr[0] && nr < rw'(size);
    na = leg_a(addr_size'(nr >> 1), nstage);
    nb = na + (addr_size'(1) << nstage);
    cur_rd = st == RUN && !r[0] && r < rw'(size);
    ctw = tw_of(addr_size'(r >> 1), stage);
  end
`ifdef FFT_MEM_SEQ_INV_EN
  logic inv;
  always_ff @(posedge clk)
    if (rst) inv <= 1'b0;
    else if (st == IDLE && start) inv <= inverse;
  wire [addr_size-1:0] ntw = inv ? -ctw : ctw;
`else
  wire [addr_size-1:0] ntw = ctw;
`endif
  fft_wb_delay #(.depth(bf_lat + 1), .aw(addr_size)) u_wb (
    .clk(clk), .rst(rst), .in_valid(nrd), .in_a(na), .in_b(nb),
    .out_valid(wb_v), .out_a(wb_a), .out_b(wb_b)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      r <= '0;
      stage <= '0;
      addr_0 <= '0;
      addr_1 <= '0;
      wr_en_0 <= 1'b0;
      wr_en_1 <= 1'b0;
      tw_idx <= '0;
      bf_in_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      st <= nst;
      r <= nr;
      stage <= nstage;
      wr_en_0 <= wb_v;
      wr_en_1 <= wb_v;
      bf_in_valid <= cur_rd;
      tw_idx <= cur_rd ? ntw : '0;
      busy <= nst == RUN;
      done <= nst == DONE;
      if (wb_v) begin
        addr_0 <= wb_a;
        addr_1 <= wb_b;
      end else if (nrd) begin
        addr_0 <= na;
        addr_1 <= nb;
      end
    end
  end
endmodule

// File: tb/tb_fft_mem_seq.sv
// tb_fft_mem_seq: cycle-exact scoreboard check of the FFT RAM sequencer (size 8)
module tb_fft_mem_seq;
  localparam int N = 8, AW = 3, LAT = 2, P = N + LAT;
  logic clk = 0, rst = 1, start = 0;
`ifdef FFT_MEM_SEQ_INV_EN
  logic inverse = 0;
`endif
  logic [AW-1:0] addr_0, addr_1, tw_idx, stage;
  logic wr_en_0, wr_en_1, bf_in_valid, busy, done;
  always #5 clk = ~clk;
  fft_mem_seq #(.size(N), .addr_size(AW), .bf_lat(LAT)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef FFT_MEM_SEQ_INV_EN
    .inverse(inverse),
`endif
    .addr_0(addr_0), .addr_1(addr_1), .wr_en_0(wr_en_0), .wr_en_1(wr_en_1),
    .tw_idx(tw_idx), .bf_in_valid(bf_in_valid), .stage(stage), .busy(busy), .done(done)
  );
  typedef struct packed {
    logic [AW-1:0] a0, a1;
    logic we0, we1, v;
    logic [AW-1:0] tw, stg;
    logic busy, done;
  } obs_t;
  obs_t q[$];
  obs_t got, exp_o, full_m, idle_m;
  int tests = 0, fails = 0;
  logic [AW-1:0] ma0 = 0, ma1 = 0;
  function automatic logic [AW-1:0] leg(input int s, input int k);
    int sp;
    sp = 1 << s;
    return AW'((k / sp) * 2 * sp + k % sp);
  endfunction
  task automatic push_run(input bit inv);
    obs_t e;
    int s, r, k, tw;
    for (int j = 1; j <= P * AW + 1; j++) begin
      e = '0;
      if (j > P * AW) begin
        e.done = 1;
        e.stg = AW'(AW - 1);
      end else begin
        s = (j - 1) / P;
        r = (j - 1) % P;
        e.busy = 1;
        e.stg = AW'(s);
        if (r % 2 == 0 && r < N) begin
          k = r / 2;
          ma0 = leg(s, k);
          ma1 = AW'(ma0 + (1 << s));
        end
        if (r % 2 == 1 && r < N) begin
          k = (r - 1) / 2;
          tw = (k % (1 << s)) * (N >> (s + 1));
          if (inv) tw = (N - tw) % N;
          e.v = 1;
          e.tw = AW'(tw);
        end
        if (r % 2 == 1 && r >= 1 + LAT) begin
          k = (r - 1 - LAT) / 2;
          ma0 = leg(s, k);
          ma1 = AW'(ma0 + (1 << s));
          e.we0 = 1;
          e.we1 = 1;
        end
      end
      e.a0 = ma0;
      e.a1 = ma1;
      q.push_back(e);
    end
  endtask
  task automatic chk(input string tag, input obs_t m);
    @(posedge clk);
    #1;
    got = {addr_0, addr_1, wr_en_0, wr_en_1, bf_in_valid, tw_idx, stage, busy, done};
    tests++;
    if (q.size() == 0) begin
      fails++;
      $error("FAIL %s scoreboard empty, got=%h", tag, got);
    end else begin
      exp_o = q.pop_front();
      assert ((got & m) === (exp_o & m)) else begin
        fails++;
        $error("FAIL %s got=%h exp=%h", tag, got & m, exp_o & m);
      end
    end
  endtask
  task automatic push_idle();
    obs_t e;
    e = '0;
    e.a0 = ma0;
    e.a1 = ma1;
    q.push_back(e);
  endtask
  task automatic run(input string tag, input bit inv, input int busy_j, input int abort_j, input bit done_start);
    push_run(inv);
    start = 1;
    for (int j = 1; j <= P * AW + 1; j++) begin
      chk($sformatf("%s_c%0d", tag, j), full_m);
      start = 0;
      if (j == busy_j) start = 1;
      if (done_start && j == P * AW) start = 1;
      if (j == abort_j) begin
        rst = 1;
        q.delete();
        ma0 = 0;
        ma1 = 0;
        push_idle();
        chk($sformatf("%s_abort", tag), full_m);
        rst = 0;
        push_idle();
        chk($sformatf("%s_abort_idle", tag), full_m);
        return;
      end
    end
    push_idle();
    chk($sformatf("%s_idle", tag), idle_m);
  endtask
  initial begin
    full_m = '1;
    idle_m = '1;
    idle_m.stg = '0;
    repeat (2) @(posedge clk);
    push_idle();
    chk("reset", full_m);
    rst = 0;
    push_idle();
    chk("post_reset_idle", full_m);
    run("fwd", 0, 0, 0, 0);
    run("busy_start", 0, 4, 0, 1);
    run("abort", 0, 0, 15, 0);
    run("after_abort", 0, 0, 0, 0);
`ifdef FFT_MEM_SEQ_INV_EN
    inverse = 1;
    run("inv", 1, 0, 0, 0);
    inverse = 0;
    run("fwd_again", 0, 0, 0, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fft_mem_seq.md
# fft_mem_seq

In-place radix-2 DIT FFT sequencer for the complex dual-port coefficient/sample RAM. For every stage and butterfly it generates the read address pair, the twiddle index and the butterfly input-valid strobe, then writes the butterfly results back to the same pair. Read and write slots alternate cycle by cycle on both RAM ports. The block sits between the top-level FFT control (start/done) and the RAM address and write-enable inputs. The butterfly datapath is external and drives the RAM data inputs directly.

## Interface
- `size`, 1024: points N; power of two, ≥ 4.
- `addr_size`, 10: log2(N); RAM address width.
- `bf_lat`, 2: cycles from `bf_in_valid` to butterfly result; must be even (elaboration `$error` otherwise).

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin transform; accepted only in IDLE.
- `addr_0`  out  addr_size: port-0 address (upper butterfly leg a).
- `addr_1`  out  addr_size: port-1 address (lower leg b).
- `wr_en_0`, `wr_en_1`  out  1: write strobes; always asserted together.
- `tw_idx`  out  addr_size: twiddle index for the butterfly whose data is on the RAM outputs.
- `bf_in_valid`  out  1: RAM read data valid this cycle (1-cycle RAM read latency).
- `stage`  out  addr_size: current stage, 0..addr_size-1.
- `busy`  out  1: high from start acceptance until `done`.
- `done`  out  1: one-cycle pulse after the last write-back.

## Operation
- States: IDLE → RUN (start) → DONE → IDLE. DONE lasts one cycle and asserts `done`.
- Butterfly k (0..N/2-1) of stage s uses span = 2^s, pos = k & (span-1), a = ((k>>s)<<(s+1)) | pos, b = a+span, tw = pos << (addr_size-1-s).
- Stage period P = N + bf_lat cycles. Relative cycle r counts 0..P-1.
- Read slot at r = 2k for k < N/2: drive addr_0=a, addr_1=b, wr_en=0. Push {a,b} into the write-back delay line.
- `bf_in_valid`=1 at r = 2k+1, with `tw_idx`=tw of butterfly k on the same cycle.
- Write slot at r = 2k+1+bf_lat: drive the delayed {a,b} and assert wr_en_0/1. Write slots are always odd, so they never collide with read slots.
- No reads are issued between the last read of a stage and r = P-1. This drains the pipeline, so the next stage's reads see completed data.
- At r = P-1 of the last stage, the next cycle enters DONE.
- In idle cycles, addresses hold their last value, with wr_en=0, bf_in_valid=0 and tw_idx=0.
- `start` while busy is ignored. `start` in the DONE cycle is also ignored.

## Timing
- All outputs are registered.
- If `start` is sampled high in IDLE at cycle c, then `busy`=1 from c+1 and stage 0 r=0 is cycle c+1.
- Total transform: addr_size·P cycles. `done` is high at cycle c+1+addr_size·P. `busy` falls in that same cycle.
- Reset value of every output is 0, and the state is IDLE. Reset mid-transform aborts on the next edge with wr_en=0 and no further writes; the RAM contents are then undefined.
- `rst` and `start` high together: reset wins.

## Configuration
- `FFT_MEM_SEQ_INV_EN` defined:
  - Adds input port `inverse` (1 bit), sampled when `start` is accepted.
  - When `inverse`=1, tw_idx = (N − tw) & (N−1), giving conjugate twiddles.
  - Addressing and timing are unchanged.
- Macro absent: no `inverse` port; forward transform only.

## Structure
- Shared package `fft_pkg` holds the state enum (IDLE/RUN/DONE) and the `clog2` constant function.
- One sub-module, `fft_wb_delay`: a (bf_lat+1)-deep shift register of {valid, a, b} that produces the write slot.
- Address and twiddle generation stays in `fft_mem_seq`.

## Test plan
All scenarios use size=8, addr_size=3, bf_lat=2, P=10.
- Stage 0 read pairs:
  - Stimulus: start.
  - Response: read pairs (0,1),(2,3),(4,5),(6,7) at r=0,2,4,6; tw 0,0,0,0.
  - Writes of the same pairs at r=3,5,7,9.
- Stages 1 and 2 read pairs, same run:
  - Stage 1 reads (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2.
  - Stage 2 reads (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3.
- Completion timing:
  - Start at cycle c → `done` pulse exactly at c+31.
  - wr_en is never high on a read slot.
  - No address is read in stage s+1 before its stage-s write.
- Start while busy:
  - Stimulus: assert start at c+5.
  - Response: no restart; same address trace and `done` at c+31.
- Reset mid-transform:
  - Stimulus: rst at stage 1 r=4.
  - Response: next cycle all outputs 0 and IDLE; a new start yields a full, correct 30-cycle trace.
- Inverse mode (`FFT_MEM_SEQ_INV_EN`, inverse=1):
  - Stage 2 tw = 0,7,6,5.
  - Addresses identical to the forward trace.
